mux_display4: RTL

Four-digit time-multiplexing scanner feeding the 7-segment decoder. It holds a 16-bit value (four hex nibbles), steps through one digit at a time at a fixed dwell rate, and drives the nibble bus `s_muxfue` and the digit anodes `an`. New values are accepted at any time but applied only at frame boundaries, so a displayed frame never mixes old and new data. Optional leading-zero blanking is provided.

---
 rtl/mux_display4.sv | 119 +++++++++++
 1 files changed

// File: rtl/mux_display4.sv
// mux_display4 -- four-digit time-multiplexed 7-segment scanner.
//
// Holds a 16-bit value (four hex nibbles) and lights one digit at a time for
// REFRESH_DIV cycles each. New values are staged in a pending register and
// only copied into the displayed register at a frame boundary (end of digit
// 3's dwell), so a frame never mixes old and new nibbles. Optional
// leading-zero blanking disables the anodes of high-order zero digits.
//
// Parameters:
//   REFRESH_DIV   : cycles each digit is lit (>= 2)
//   AN_ACTIVE_LOW : 1 -> enabled anode driven 0, 0 -> enabled anode driven 1
// Ports:
//   clk        in  : system clock, rising edge
//   rst        in  : synchronous active-high reset
//   data_in    in  : [15:0] value to display, nibble k -> digit k (0 = rightmost)
//   load       in  : one-cycle capture request for data_in
//   blank_lz   in  : leading-zero blanking enable
//   s_muxfue   out : [3:0] nibble of the scanned digit
//   an         out : [3:0] anode enables, one-hot in scanned position
//   digit_idx  out : [1:0] scanned digit index
//   frame_tick out : high on the frame boundary cycle
module mux_display4 #(
  parameter int REFRESH_DIV   = 27000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  s_muxfue,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          blank_q, blank_d;

  logic          term;
  logic          boundary;
  logic          digit_blank;
  logic [3:0]    onehot;
  logic [3:0]    en;

  always_comb begin
    term     = (presc_q == PRESC_LAST);
    boundary = term && (idx_q == 2'd3);

    presc_d  = term ? '0 : presc_q + PW'(1);
    idx_d    = term ? idx_q + 2'd1 : idx_q;

    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (boundary) begin
      // A load arriving on the boundary itself bypasses the pending stage
      // and supersedes anything already staged.
      if (load) begin
        disp_d   = data_in;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (load) begin
      pend_d   = data_in;
      pend_v_d = 1'b1;
    end

    // Registered so every output is driven from flops only; blanking takes
    // effect one cycle after blank_lz changes, with no frame alignment.
    blank_d = blank_lz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      disp_q   <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      blank_q  <= blank_d;
    end
  end

  always_comb begin
    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
    unique case (idx_q)
      2'd0:    digit_blank = 1'b0;
      2'd1:    digit_blank = (disp_q[15:4]  == 12'h000);
      2'd2:    digit_blank = (disp_q[15:8]  == 8'h00);
      default: digit_blank = (disp_q[15:12] == 4'h0);
    endcase

    onehot     = 4'b0001 << idx_q;
    en         = (blank_q && digit_blank) ? 4'b0000 : onehot;
    an         = AN_ACTIVE_LOW ? ~en : en;
    s_muxfue   = disp_q[{idx_q, 2'b00} +: 4];
    digit_idx  = idx_q;
    frame_tick = boundary;
  end

endmodule
